// File: rtl/countdown_timer.sv
// Loadable down-counter with a single-cycle expiry pulse and optional
// auto-reload for periodic tick generation.
module countdown_timer #(
  parameter int COUNT_WIDTH = 8,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   en,
  input  logic                   stop,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
  localparam bit RELOAD_EN = (AUTO_RELOAD != 0);

  state_t                 state_q, state_nxt;
  logic [COUNT_WIDTH-1:0] count_q, count_nxt;
  logic [COUNT_WIDTH-1:0] reload_q, reload_nxt;
  logic                   expiry;

  // Saturating decrement: never wraps below zero.
  function automatic logic [COUNT_WIDTH-1:0] dec_sat(input logic [COUNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  // Value taken on the expiring edge: back to the start value or parked at zero.
  function automatic logic [COUNT_WIDTH-1:0] expiry_value(input logic [COUNT_WIDTH-1:0] rl);
    return RELOAD_EN ? rl : '0;
  endfunction

  assign expiry = en && (count_q == ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    if (load) begin
      reload_nxt = load_value;
      count_nxt  = load_value;
      state_nxt  = (load_value != '0) ? RUN : IDLE;
    end else if (stop && (state_q != IDLE)) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_nxt = IDLE;
        end
        RUN: begin
          if (expiry) begin
            count_nxt = expiry_value(reload_q);
            state_nxt = EXPIRE;
          end else if (en) begin
            count_nxt = dec_sat(count_q);
          end
        end
        EXPIRE: begin
          // One-shot mode parks at zero; periodic mode keeps counting from here.
          if (!RELOAD_EN) begin
            state_nxt = IDLE;
          end else if (expiry) begin
            count_nxt = expiry_value(reload_q);
            state_nxt = EXPIRE;
          end else begin
            if (en) count_nxt = dec_sat(count_q);
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == EXPIRE);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one-shot and auto-reload instances driven in
// parallel, checked against a rule-level reference model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_value;
  logic       en;
  logic       stop;
  logic [7:0] count0, count1;
  logic       busy0, busy1, done0, done1;

  int checks   = 0;
  int failures = 0;

  // Reference model, index 0 = one-shot, 1 = auto-reload.
  int m_cnt[2];
  int m_rel[2];
  bit m_active[2];
  bit m_pulse[2];

  countdown_timer #(.COUNT_WIDTH(8), .AUTO_RELOAD(0)) u_os (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .en(en), .stop(stop), .count(count0), .busy(busy0), .done(done0)
  );

  countdown_timer #(.COUNT_WIDTH(8), .AUTO_RELOAD(1)) u_ar (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .en(en), .stop(stop), .count(count1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_active[i] = 0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_edge(input bit ld, input int lv, input bit st, input bit e);
    for (int i = 0; i < 2; i++) begin
      if (ld) begin
        m_rel[i] = lv; m_cnt[i] = lv; m_active[i] = (lv != 0); m_pulse[i] = 0;
      end else if (st && m_active[i]) begin
        m_active[i] = 0; m_pulse[i] = 0;
      end else if (m_active[i]) begin
        if (m_pulse[i] && i == 0) begin
          m_active[i] = 0; m_pulse[i] = 0;
        end else if (e && m_cnt[i] == 1) begin
          m_cnt[i] = (i == 1) ? m_rel[i] : 0; m_pulse[i] = 1;
        end else begin
          if (e) m_cnt[i] = m_cnt[i] - 1;
          m_pulse[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".os.count"}, count0, m_cnt[0]);
    chk({tag, ".os.busy"},  busy0,  m_active[0]);
    chk({tag, ".os.done"},  done0,  m_pulse[0]);
    chk({tag, ".ar.count"}, count1, m_cnt[1]);
    chk({tag, ".ar.busy"},  busy1,  m_active[1]);
    chk({tag, ".ar.done"},  done1,  m_pulse[1]);
  endtask

  task automatic step(input string tag, input bit ld, input logic [7:0] lv, input bit st, input bit e);
    load = ld; load_value = lv; stop = st; en = e;
    @(posedge clk);
    model_edge(ld, int'(lv), st, e);
    #1;
    check_all(tag);
  endtask

  initial begin
    int pc;
    int n;
    bit got;
    rst = 1'b0; load = 1'b0; load_value = '0; en = 1'b0; stop = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #3 rst = 1'b1;

    // One-shot: load 3 then count down with en held high.
    step("os_load3", 1, 8'd3, 0, 1);
    chk("os_load3_count", count0, 3);
    step("os_c2", 0, 0, 0, 1);
    step("os_c1", 0, 0, 0, 1);
    step("os_c0", 0, 0, 0, 1);
    chk("os_done_pulse", done0, 1);
    chk("os_count_zero", count0, 0);
    step("os_idle", 0, 0, 0, 1);
    chk("os_busy_fall", busy0, 0);

    // Periodic: reload 4 gives a done every 4th cycle.
    step("ar_load4", 1, 8'd4, 0, 1);
    pc = 0;
    for (int i = 0; i < 12; i++) begin
      step("ar_run4", 0, 0, 0, 1);
      if (done1) pc++;
    end
    chk("ar_pulse_count4", pc, 3);

    // Reload 1 holds done continuously.
    step("ar_load1", 1, 8'd1, 0, 1);
    pc = 0;
    for (int i = 0; i < 6; i++) begin
      step("ar_run1", 0, 0, 0, 1);
      if (done1) pc++;
    end
    chk("ar_done_held", pc, 6);

    // Priority: load beats en, stop beats en.
    step("pr_load5", 1, 8'd5, 0, 1);
    for (int i = 0; i < 3; i++) step("pr_dec", 0, 0, 0, 1);
    chk("pr_count2", count0, 2);
    step("pr_load7", 1, 8'd7, 0, 1);
    chk("pr_load_no_dec", count0, 7);
    for (int i = 0; i < 5; i++) step("pr_dec7", 0, 0, 0, 1);
    step("pr_stop", 0, 0, 1, 1);
    chk("pr_stop_count", count0, 2);
    chk("pr_stop_busy", busy0, 0);
    chk("pr_stop_done", done0, 0);

    // Load 0 stays idle with no pulse.
    step("z_load0", 1, 8'd0, 0, 1);
    pc = 0;
    for (int i = 0; i < 5; i++) begin
      step("z_idle", 0, 0, 0, 1);
      if (done0 || done1 || busy0 || busy1) pc++;
    end
    chk("z_no_activity", pc, 0);

    // Load 255 with en toggling every cycle.
    step("l255_load", 1, 8'd255, 0, 0);
    got = 0; n = 0;
    for (int i = 1; i <= 600 && !got; i++) begin
      step("l255_run", 0, 0, 0, (i % 2) == 0);
      if (done0) begin got = 1; n = i; end
    end
    chk("l255_latency", n, 510);

    // Load during EXPIRE restarts after the current done cycle.
    step("le_load2", 1, 8'd2, 0, 1);
    step("le_c1", 0, 0, 0, 1);
    step("le_exp", 0, 0, 0, 1);
    chk("le_done_now", done0, 1);
    step("le_reload", 1, 8'd6, 0, 1);
    chk("le_count6", count0, 6);
    chk("le_busy", busy0, 1);
    chk("le_done_clear", done0, 0);

    // Asynchronous reset mid-count at count 5.
    step("rs_load8", 1, 8'd8, 0, 1);
    for (int i = 0; i < 3; i++) step("rs_dec", 0, 0, 0, 1);
    chk("rs_count5", count0, 5);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("rs_async");
    @(posedge clk);
    #1;
    check_all("rs_held");
    #2 rst = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] lv;
      bit ld, st, e;
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      step("rand", ld, lv, st, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
